// File: rtl/dual_slot_rr_arbiter_pkg.sv
// Shared types and helpers for the dual-slot round-robin arbiter.
package dsrr_pkg;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_e;

  localparam int NUM_SLOTS = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dual_slot_rr_arbiter_lowest_two_pick.sv
// Finds the two lowest set bits of a vector, returned one-hot with found flags.
module lowest_two_pick #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] first_oh_o,
  output logic             first_found_o,
  output logic [WIDTH-1:0] second_oh_o,
  output logic             second_found_o
);

  logic [WIDTH-1:0] rest;

  // x & -x isolates the lowest set bit
  assign first_oh_o     = vec_i & (~vec_i + WIDTH'(1));
  assign first_found_o  = |vec_i;
  assign rest           = vec_i & ~first_oh_o;
  assign second_oh_o    = rest & (~rest + WIDTH'(1));
  assign second_found_o = |rest;

endmodule

// File: rtl/dual_slot_rr_arbiter.sv
// Two-slot round-robin arbiter; grants are held until the slot reports done.
// Optional hold timeout enabled by defining DSRR_TIMEOUT_EN.
module dual_slot_rr_arbiter
  import dsrr_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int TMO_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH-1:0]         req_i,
  input  logic [1:0]               done_i,
  output logic [WIDTH-1:0]         grant_o,
  output logic [1:0]               slot_vld_o,
  output logic [$clog2(WIDTH)-1:0] slot0_idx_o,
  output logic [$clog2(WIDTH)-1:0] slot1_idx_o
`ifdef DSRR_TIMEOUT_EN
  ,
  output logic [1:0]               timeout_o
`endif
);

  localparam int IW = idx_w(WIDTH);

  slot_state_e [NUM_SLOTS-1:0]          state_q;
  logic        [NUM_SLOTS-1:0][IW-1:0]  idx_q;
  logic        [IW-1:0]                 ptr_q, ptr_d;
  logic        [WIDTH-1:0]              grant_q, grant_d;

  logic [WIDTH-1:0]   owner_mask, cand, cand_rot;
  logic [2*WIDTH-1:0] cand_dbl, first_dbl, second_dbl;
  logic [WIDTH-1:0]   first_oh_rot, second_oh_rot;
  logic               first_found, second_found;
  logic [IW-1:0]      first_idx, second_idx;

  logic [NUM_SLOTS-1:0]         pick, keep, tmo_fire;
  logic [NUM_SLOTS-1:0][IW-1:0] pick_idx;

  function automatic logic [IW-1:0] oh2idx(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == WIDTH - 1) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    owner_mask = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (state_q[s] == SLOT_BUSY) owner_mask[idx_q[s]] = 1'b1;
    end
  end

  assign cand     = req_i & ~owner_mask;
  // Rotate so that ptr_q lands on bit 0, pick, then rotate the picks back
  assign cand_dbl = {cand, cand} >> ptr_q;
  assign cand_rot = cand_dbl[WIDTH-1:0];

  lowest_two_pick #(.WIDTH(WIDTH)) u_pick (
    .vec_i          (cand_rot),
    .first_oh_o     (first_oh_rot),
    .first_found_o  (first_found),
    .second_oh_o    (second_oh_rot),
    .second_found_o (second_found)
  );

  assign first_dbl  = {first_oh_rot, first_oh_rot} << ptr_q;
  assign second_dbl = {second_oh_rot, second_oh_rot} << ptr_q;
  assign first_idx  = oh2idx(first_dbl[2*WIDTH-1:WIDTH]);
  assign second_idx = oh2idx(second_dbl[2*WIDTH-1:WIDTH]);

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    ptr_d    = ptr_q;
    if (state_q[0] == SLOT_FREE && state_q[1] == SLOT_FREE) begin
      pick[0]     = first_found;
      pick_idx[0] = first_idx;
      pick[1]     = second_found;
      pick_idx[1] = second_idx;
      if (second_found)     ptr_d = wrap_inc(second_idx);
      else if (first_found) ptr_d = wrap_inc(first_idx);
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (state_q[s] == SLOT_FREE) begin
          pick[s]     = first_found;
          pick_idx[s] = first_idx;
          if (first_found) ptr_d = wrap_inc(first_idx);
        end
      end
    end
  end

`ifdef DSRR_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);

  logic [NUM_SLOTS-1:0][CW-1:0] cnt_q;
  logic [1:0]                   timeout_q;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      tmo_fire[s] = (state_q[s] == SLOT_BUSY) && !done_i[s] &&
                    (cnt_q[s] == CW'(TMO_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (pick[s])                       cnt_q[s] <= '0;
        else if (state_q[s] == SLOT_BUSY)  cnt_q[s] <= cnt_q[s] + CW'(1);
      end
      timeout_q <= tmo_fire;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_CYCLES;
  assign tmo_fire       = '0;
`endif

  always_comb begin
    grant_d = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      keep[s] = (state_q[s] == SLOT_BUSY) && !done_i[s] && !tmo_fire[s];
      if (keep[s])      grant_d[idx_q[s]]    = 1'b1;
      else if (pick[s]) grant_d[pick_idx[s]] = 1'b1;
    end
  end

  // A slot released at this edge stays FREE for one cycle before it can pick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= SLOT_FREE;
      end
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        case (state_q[s])
          SLOT_FREE: begin
            if (pick[s]) begin
              state_q[s] <= SLOT_BUSY;
              idx_q[s]   <= pick_idx[s];
            end
          end
          SLOT_BUSY: begin
            if (!keep[s]) state_q[s] <= SLOT_FREE;
          end
          default: state_q[s] <= SLOT_FREE;
        endcase
      end
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o     = grant_q;
  assign slot_vld_o  = {state_q[1] == SLOT_BUSY, state_q[0] == SLOT_BUSY};
  assign slot0_idx_o = idx_q[0];
  assign slot1_idx_o = idx_q[1];

endmodule

// File: tb/tb_dual_slot_rr_arbiter.sv
// Scoreboard bench for dual_slot_rr_arbiter with WIDTH=12.
module tb_dual_slot_rr_arbiter;

  localparam int WIDTH = 12;
  localparam int TMO   = 16;
  localparam int IW    = $clog2(WIDTH);

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] grant;
    logic [1:0]       vld;
    logic [IW-1:0]    idx0;
    logic [IW-1:0]    idx1;
    logic [IW-1:0]    ptr;
    logic [1:0]       tmo;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] req_i;
  logic [1:0]       done_i;
  logic [WIDTH-1:0] grant;
  logic [1:0]       vld;
  logic [IW-1:0]    idx0, idx1;
  logic [1:0]       tmo;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dual_slot_rr_arbiter #(.WIDTH(WIDTH), .TMO_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_i),
    .done_i      (done_i),
    .grant_o     (grant),
    .slot_vld_o  (vld),
    .slot0_idx_o (idx0),
    .slot1_idx_o (idx1)
`ifdef DSRR_TIMEOUT_EN
    ,
    .timeout_o   (tmo)
`endif
  );

`ifndef DSRR_TIMEOUT_EN
  assign tmo = 2'b00;
`endif

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
    check_val({e.tag, ".vld"},   32'(vld),   32'(e.vld));
    if (e.vld[0]) check_val({e.tag, ".idx0"}, 32'(idx0), 32'(e.idx0));
    if (e.vld[1]) check_val({e.tag, ".idx1"}, 32'(idx1), 32'(e.idx1));
    check_val({e.tag, ".ptr"}, 32'(dut.ptr_q), 32'(e.ptr));
`ifdef DSRR_TIMEOUT_EN
    check_val({e.tag, ".tmo"}, 32'(tmo), 32'(e.tmo));
`endif
  endtask

  task automatic step(input string tag, input logic [WIDTH-1:0] req, input logic [1:0] done,
                      input logic [WIDTH-1:0] g, input logic [1:0] v, input int i0,
                      input int i1, input int p, input logic [1:0] t);
    exp_t e;
    @(negedge clk);
    req_i  = req;
    done_i = done;
    e.tag  = tag;
    e.grant = g;
    e.vld  = v;
    e.idx0 = IW'(i0);
    e.idx1 = IW'(i1);
    e.ptr  = IW'(p);
    e.tmo  = t;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    rst_n  = 1'b0;
    req_i  = '0;
    done_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.grant", 32'(grant), 0);
    check_val("rst.vld",   32'(vld),   0);
    check_val("rst.idx0",  32'(idx0),  0);
    check_val("rst.idx1",  32'(idx1),  0);
    check_val("rst.ptr",   32'(dut.ptr_q), 0);
    check_val("rst.tmo",   32'(tmo),   0);
    @(negedge clk);
    rst_n = 1'b1;

    step("pair",      12'h00A, 2'b00, 12'h00A, 2'b11, 1, 3, 4, 2'b00);
    step("rel0",      12'h00B, 2'b01, 12'h008, 2'b10, 0, 3, 4, 2'b00);
    step("regrant0",  12'h00B, 2'b00, 12'h009, 2'b11, 0, 3, 1, 2'b00);
    step("relboth",   12'h000, 2'b11, 12'h000, 2'b00, 0, 0, 1, 2'b00);
    step("to_ptr11",  12'h400, 2'b00, 12'h400, 2'b01, 10, 0, 11, 2'b00);
    step("rel_a",     12'h000, 2'b01, 12'h000, 2'b00, 0, 0, 11, 2'b00);
    step("wrap",      12'h801, 2'b00, 12'h801, 2'b11, 11, 0, 1, 2'b00);
    step("rel_b",     12'h000, 2'b11, 12'h000, 2'b00, 0, 0, 1, 2'b00);
    step("to_ptr0",   12'h800, 2'b00, 12'h800, 2'b01, 11, 0, 0, 2'b00);
    step("rel_c",     12'h000, 2'b01, 12'h000, 2'b00, 0, 0, 0, 2'b00);
    step("single",    12'h010, 2'b00, 12'h010, 2'b01, 4, 0, 5, 2'b00);
    step("drop1",     12'h000, 2'b00, 12'h010, 2'b01, 4, 0, 5, 2'b00);
    step("drop2",     12'h000, 2'b00, 12'h010, 2'b01, 4, 0, 5, 2'b00);
    step("done_free", 12'h000, 2'b10, 12'h010, 2'b01, 4, 0, 5, 2'b00);
    step("rel_d",     12'h000, 2'b01, 12'h000, 2'b00, 0, 0, 5, 2'b00);
    step("rot_order", 12'h030, 2'b00, 12'h030, 2'b11, 5, 4, 5, 2'b00);
    step("rel_e",     12'h030, 2'b01, 12'h010, 2'b10, 0, 4, 5, 2'b00);
    step("no_dual",   12'h030, 2'b00, 12'h030, 2'b11, 5, 4, 6, 2'b00);
    step("rel_f",     12'h030, 2'b10, 12'h020, 2'b01, 5, 0, 6, 2'b00);
    step("slot1_only",12'h031, 2'b00, 12'h021, 2'b11, 5, 0, 1, 2'b00);

    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst.grant", 32'(grant), 0);
    check_val("arst.vld",   32'(vld),   0);
    check_val("arst.ptr",   32'(dut.ptr_q), 0);
    check_val("arst.idx0",  32'(idx0),  0);
    req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  12'h003, 2'b00, 12'h003, 2'b11, 0, 1, 2, 2'b00);

`ifdef DSRR_TIMEOUT_EN
    step("rel_g",     12'h000, 2'b11, 12'h000, 2'b00, 0, 0, 2, 2'b00);
    step("tmo_grant", 12'h020, 2'b00, 12'h020, 2'b01, 5, 0, 6, 2'b00);
    for (int k = 1; k < TMO; k++) begin
      step($sformatf("hold%0d", k), 12'h000, 2'b00, 12'h020, 2'b01, 5, 0, 6, 2'b00);
    end
    step("tmo_fire",  12'h000, 2'b00, 12'h000, 2'b00, 0, 0, 6, 2'b01);
    step("tmo_clear", 12'h000, 2'b00, 12'h000, 2'b00, 0, 0, 6, 2'b00);
    step("tmo_grant2",12'h020, 2'b00, 12'h020, 2'b01, 5, 0, 6, 2'b00);
    for (int k = 1; k < TMO; k++) begin
      step($sformatf("hold2_%0d", k), 12'h000, 2'b00, 12'h020, 2'b01, 5, 0, 6, 2'b00);
    end
    step("done_wins", 12'h000, 2'b01, 12'h000, 2'b00, 0, 0, 6, 2'b00);
    step("no_pulse",  12'h000, 2'b00, 12'h000, 2'b00, 0, 0, 6, 2'b00);
`endif

    check_val("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
